cipher_rx_loader: RTL and testbench

// - Assembles an N-byte ciphertext from the UART receiver's byte handshake into one wide register for codebreaker.
// - Replaces the free-running shift register at the top level with a counted, acknowledged loader.
// - Adds an inter-byte timeout, overrun detection and a start pulse held off while the codebreaker is busy.
// - Sits between rx and codebreaker in codebreaker_top.

---
 rtl/cipher_rx_loader_if.sv | 18 +
 rtl/cipher_rx_loader.sv | 197 +++++++++++++++++++
 tb/tb_cipher_rx_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_rx_loader_if.sv
// Byte handshake between the UART receiver (master) and the ciphertext loader (slave).
interface cipher_rx_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ack
  );
endinterface

// File: rtl/cipher_rx_loader.sv
// Counted, acknowledged loader that assembles NUM_BYTES UART bytes (first byte = MSB) for the codebreaker.
// Define CIPHER_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module cipher_rx_loader #(
  parameter int                     NUM_BYTES     = 16,
  parameter int                     CLK_FREQUENCY = 100_000_000,
  parameter int                     TIMEOUT_US    = 50_000,
  parameter bit                     AUTO_START    = 1'b1,
  parameter logic [8*NUM_BYTES-1:0] RESET_VALUE   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  cipher_rx_loader_if.slave              rx,
  input  logic                           clear,
  input  logic                           cb_busy,
  output logic [8*NUM_BYTES-1:0]         cipher_out,
  output logic [$clog2(NUM_BYTES+2)-1:0] byte_count,
  output logic                           loaded,
  output logic                           start_out,
  output logic                           timeout_err,
  output logic                           overrun_err,
  output logic                           chk_err
);

  localparam int W              = 8 * NUM_BYTES;
  localparam int CW             = $clog2(NUM_BYTES + 2);
  localparam int TIMEOUT_CYCLES = TIMEOUT_US * (CLK_FREQUENCY / 1_000_000);
  localparam int TW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef CIPHER_LOADER_CHECKSUM_EN
  localparam int FRAME_BYTES    = NUM_BYTES + 1;
`else
  localparam int FRAME_BYTES    = NUM_BYTES;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_LOADED
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [TW-1:0]   idle_cnt;
  logic [TW-1:0]   idle_next;
  logic            pending;
  logic            pending_next;
  logic [W-1:0]    cipher_next;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   count_inc;
  logic            loaded_next;
  logic            start_next;
  logic            timeout_next;
  logic            overrun_next;

  logic            accept;
  logic            fill_accept;
  logic            shift_en;
  logic            frame_done;
  logic            frame_ok;
  logic            chk_byte;
  logic            timer_hit;

  // One accept per rx byte: ack rises after the accept and holds while rx_valid stays high.
  assign accept      = rx.rx_valid && !rx.rx_ack;
  assign fill_accept = accept && (state != S_LOADED);
  assign shift_en    = fill_accept && !chk_byte;
  assign count_inc   = byte_count + CW'(1);
  assign frame_done  = fill_accept && (count_inc == CW'(FRAME_BYTES));
  assign timer_hit   = (state == S_FILL) && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FILL: begin
          if (frame_done)       state_next = frame_ok ? S_LOADED : S_IDLE;
          else if (fill_accept) state_next = S_FILL;
          else if (timer_hit)   state_next = S_IDLE;
        end
        S_LOADED: state_next = S_LOADED;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cipher_next  = cipher_out;
    count_next   = byte_count;
    loaded_next  = loaded;
    pending_next = pending;
    start_next   = 1'b0;
    timeout_next = timeout_err;
    overrun_next = overrun_err;
    idle_next    = idle_cnt;
    if (clear) begin
      cipher_next  = RESET_VALUE;
      count_next   = '0;
      loaded_next  = 1'b0;
      pending_next = 1'b0;
      timeout_next = 1'b0;
      overrun_next = 1'b0;
      idle_next    = '0;
    end else begin
      if (shift_en)
        cipher_next = W'({cipher_out, rx.rx_data});
      if (fill_accept) begin
        count_next = (frame_done && !frame_ok) ? '0 : count_inc;
        idle_next  = '0;
      end else if (timer_hit) begin
        cipher_next  = RESET_VALUE;
        count_next   = '0;
        timeout_next = 1'b1;
        idle_next    = '0;
      end else if (state == S_FILL) begin
        idle_next = idle_cnt + TW'(1);
      end
      if (frame_done && frame_ok) begin
        loaded_next  = 1'b1;
        pending_next = AUTO_START;
      end
      // Bytes arriving on a loaded frame are acked and thrown away.
      if (state == S_LOADED) begin
        if (accept)
          overrun_next = 1'b1;
        if (pending && !cb_busy) begin
          start_next   = 1'b1;
          pending_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      rx.rx_ack   <= 1'b0;
      cipher_out  <= RESET_VALUE;
      byte_count  <= '0;
      loaded      <= 1'b0;
      pending     <= 1'b0;
      start_out   <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state       <= state_next;
      rx.rx_ack   <= rx.rx_valid;
      cipher_out  <= cipher_next;
      byte_count  <= count_next;
      loaded      <= loaded_next;
      pending     <= pending_next;
      start_out   <= start_next;
      timeout_err <= timeout_next;
      overrun_err <= overrun_next;
      idle_cnt    <= idle_next;
    end
  end

`ifdef CIPHER_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic [7:0] acc_next;
  logic       chk_err_next;

  // The byte after the full payload is the checksum; it is compared, never shifted in.
  assign chk_byte = (count_inc == CW'(FRAME_BYTES));
  assign frame_ok = (rx.rx_data == chk_acc);

  always_comb begin
    acc_next     = chk_acc;
    chk_err_next = chk_err;
    if (clear) begin
      acc_next     = '0;
      chk_err_next = 1'b0;
    end else if (shift_en) begin
      acc_next = ((state == S_IDLE) ? 8'h00 : chk_acc) ^ rx.rx_data;
    end else if (frame_done && !frame_ok) begin
      chk_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) chk_err <= 1'b0;
    else      chk_err <= chk_err_next;
    chk_acc <= acc_next;
  end
`else
  assign chk_byte = 1'b0;
  assign frame_ok = 1'b1;
  assign chk_err  = 1'b0;
`endif

  a_start_single: assert property (@(posedge clk) disable iff (!rst) start_out |=> !start_out);
  a_loaded_state: assert property (@(posedge clk) disable iff (!rst) loaded == (state == S_LOADED));

endmodule

// File: tb/tb_cipher_rx_loader.sv
// Randomized self-checking bench for cipher_rx_loader against a frame-level reference model.
module tb_cipher_rx_loader;
  localparam int N = 16;
  localparam logic [8*N-1:0] RV = 128'h5A5A_C3C3_0F0F_F0F0_1234_5678_9ABC_DEF0;
`ifdef CIPHER_LOADER_CHECKSUM_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clear = 1'b0;
  logic           cb_busy = 1'b0;
  logic [8*N-1:0] cipher_out;
  logic [4:0]     byte_count;
  logic           loaded, start_out, timeout_err, overrun_err, chk_err;

  cipher_rx_loader_if rx_if();

  cipher_rx_loader #(
    .NUM_BYTES(N), .CLK_FREQUENCY(100_000_000), .TIMEOUT_US(10),
    .AUTO_START(1'b1), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx_if), .clear(clear), .cb_busy(cb_busy),
    .cipher_out(cipher_out), .byte_count(byte_count), .loaded(loaded),
    .start_out(start_out), .timeout_err(timeout_err), .overrun_err(overrun_err),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   ack_rises = 0;
  int   start_pulses = 0;
  logic ack_q = 1'b0;

  always @(negedge clk) begin
    if (rx_if.rx_ack === 1'b1 && ack_q !== 1'b1) ack_rises++;
    ack_q = rx_if.rx_ack;
    if (start_out === 1'b1) start_pulses++;
  end

  // Frame-level model: what the loader should hold after each accepted byte.
  logic [8*N-1:0] m_cipher;
  int             m_count;
  int             m_starts = 0;
  bit             m_loaded, m_timeout, m_overrun, m_chk;
  logic [7:0]     m_xor;

  function void model_clear();
    m_cipher  = RV;
    m_count   = 0;
    m_loaded  = 0;
    m_timeout = 0;
    m_overrun = 0;
    m_chk     = 0;
    m_xor     = 8'h00;
  endfunction

  function void model_timeout();
    m_cipher  = RV;
    m_count   = 0;
    m_timeout = 1;
  endfunction

  function void model_accept(input logic [7:0] b);
    if (m_loaded) begin
      m_overrun = 1;
    end else if (FRAME > N && m_count == N) begin
      if (b == m_xor) begin
        m_count++;
        m_loaded = 1;
        m_starts++;
      end else begin
        m_chk   = 1;
        m_count = 0;
      end
    end else begin
      if (m_count == 0) m_xor = 8'h00;
      m_cipher = {m_cipher[8*N-9:0], b};
      m_xor    = m_xor ^ b;
      m_count++;
      if (m_count == FRAME) begin
        m_loaded = 1;
        m_starts++;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_if.rx_valid = 1'b0;
    model_accept(b);
  endtask

  task automatic send_frame(input logic [7:0] pl [N], input int hold);
`ifdef CIPHER_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    for (int i = 0; i < N; i++) begin
      send_byte(pl[i], (hold > 0) ? hold : int'($urandom_range(4, 1)));
      if (hold == 0) repeat ($urandom_range(3, 0)) @(negedge clk);
`ifdef CIPHER_LOADER_CHECKSUM_EN
      x = x ^ pl[i];
`endif
    end
`ifdef CIPHER_LOADER_CHECKSUM_EN
    send_byte(x, 2);
`endif
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    total++;
    if (cipher_out !== RV) begin
      bad++; $display("FAIL reset_cipher: got %h expected %h", cipher_out, RV);
    end
    total++;
    if ({byte_count, loaded, start_out, timeout_err, overrun_err, chk_err, rx_if.rx_ack} !== 11'b0) begin
      bad++; $display("FAIL reset_flags: got cnt=%0d ld=%b st=%b to=%b ov=%b ck=%b ack=%b expected all 0",
                      byte_count, loaded, start_out, timeout_err, overrun_err, chk_err, rx_if.rx_ack);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    logic [7:0] pl [N];
    int a0, s0;
    for (int i = 0; i < N; i++) pl[i] = 8'(i);
    a0 = ack_rises;
    s0 = start_pulses;
    send_frame(pl, 3);
    repeat (4) @(negedge clk);
    total++;
    if (cipher_out !== 128'h000102030405060708090A0B0C0D0E0F) begin
      bad++; $display("FAIL frame_cipher: got %h expected 000102030405060708090a0b0c0d0e0f", cipher_out);
    end
    total++;
    if (loaded !== 1'b1 || byte_count !== 5'(FRAME)) begin
      bad++; $display("FAIL frame_loaded: got loaded=%b cnt=%0d expected 1/%0d", loaded, byte_count, FRAME);
    end
    total++;
    if (ack_rises - a0 !== FRAME) begin
      bad++; $display("FAIL frame_acks: got %0d expected %0d", ack_rises - a0, FRAME);
    end
    total++;
    if (start_pulses - s0 !== 1) begin
      bad++; $display("FAIL frame_start: got %0d pulses expected 1", start_pulses - s0);
    end
  endtask

  task automatic test_overrun_clear();
    int a0;
    a0 = ack_rises;
    send_byte(8'($urandom), 2);
    repeat (2) @(negedge clk);
    total++;
    if (ack_rises - a0 !== 1 || overrun_err !== m_overrun) begin
      bad++; $display("FAIL overrun_flag: got acks=%0d ov=%b expected 1/%b", ack_rises - a0, overrun_err, m_overrun);
    end
    total++;
    if (cipher_out !== m_cipher || byte_count !== 5'(m_count) || loaded !== 1'b1) begin
      bad++; $display("FAIL overrun_hold: got %h cnt=%0d ld=%b expected %h cnt=%0d ld=1",
                      cipher_out, byte_count, loaded, m_cipher, m_count);
    end
    do_clear();
    total++;
    if ({loaded, byte_count, overrun_err, timeout_err, chk_err, start_out} !== 10'b0 || cipher_out !== RV) begin
      bad++; $display("FAIL clear_state: got ld=%b cnt=%0d ov=%b to=%b ck=%b %h expected zeros and %h",
                      loaded, byte_count, overrun_err, timeout_err, chk_err, cipher_out, RV);
    end
  endtask

  task automatic test_busy();
    logic [7:0] pl [N];
    int s0, hi;
    for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
    cb_busy = 1'b1;
    s0 = start_pulses;
    send_frame(pl, 0);
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (start_out !== 1'b0) hi++;
    end
    total++;
    if (hi !== 0 || loaded !== 1'b1) begin
      bad++; $display("FAIL busy_hold: got %0d start cycles loaded=%b expected 0/1", hi, loaded);
    end
    cb_busy = 1'b0;
    @(negedge clk);
    total++;
    if (start_out !== 1'b1) begin
      bad++; $display("FAIL busy_release: got start=%b expected 1", start_out);
    end
    @(negedge clk);
    total++;
    if (start_out !== 1'b0 || start_pulses - s0 !== 1) begin
      bad++; $display("FAIL busy_single: got start=%b pulses=%0d expected 0/1", start_out, start_pulses - s0);
    end
    total++;
    if (cipher_out !== m_cipher) begin
      bad++; $display("FAIL busy_cipher: got %h expected %h", cipher_out, m_cipher);
    end
    do_clear();
  endtask

  task automatic test_random_frames();
    logic [7:0] pl [N];
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
      send_frame(pl, 0);
      repeat (4) @(negedge clk);
      total++;
      if (cipher_out !== m_cipher || loaded !== m_loaded || byte_count !== 5'(m_count)) begin
        bad++; $display("FAIL rand_frame%0d: got %h ld=%b cnt=%0d expected %h ld=%b cnt=%0d",
                        f, cipher_out, loaded, byte_count, m_cipher, m_loaded, m_count);
      end
      do_clear();
    end
  endtask

  task automatic test_timeout();
    logic [7:0] pl [N];
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 3);
    repeat (900) @(negedge clk);
    total++;
    if (byte_count !== 5'(m_count) || timeout_err !== 1'b0 || cipher_out !== m_cipher) begin
      bad++; $display("FAIL timeout_early: got cnt=%0d to=%b %h expected cnt=%0d to=0 %h",
                      byte_count, timeout_err, cipher_out, m_count, m_cipher);
    end
    repeat (110) @(negedge clk);
    model_timeout();
    total++;
    if (byte_count !== 5'd0 || cipher_out !== RV || timeout_err !== m_timeout || loaded !== 1'b0) begin
      bad++; $display("FAIL timeout_fire: got cnt=%0d to=%b ld=%b %h expected 0/1/0 %h",
                      byte_count, timeout_err, loaded, cipher_out, RV);
    end
    for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
    send_frame(pl, 0);
    repeat (4) @(negedge clk);
    total++;
    if (cipher_out !== m_cipher || loaded !== 1'b1 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_reload: got %h ld=%b to=%b expected %h ld=1 to=1",
                      cipher_out, loaded, timeout_err, m_cipher);
    end
    do_clear();
  endtask

  task automatic test_clear_collision();
    logic [7:0] pl [N];
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2);
    @(negedge clk);
    rx_if.rx_data  = 8'($urandom);
    rx_if.rx_valid = 1'b1;
    clear          = 1'b1;
    @(negedge clk);
    clear          = 1'b0;
    rx_if.rx_valid = 1'b0;
    model_clear();
    total++;
    if (rx_if.rx_ack !== 1'b1 || byte_count !== 5'd0 || cipher_out !== RV) begin
      bad++; $display("FAIL collide_drop: got ack=%b cnt=%0d %h expected ack=1 cnt=0 %h",
                      rx_if.rx_ack, byte_count, cipher_out, RV);
    end
    @(negedge clk);
    total++;
    if (rx_if.rx_ack !== 1'b0 || byte_count !== 5'd0) begin
      bad++; $display("FAIL collide_ackdone: got ack=%b cnt=%0d expected 0/0", rx_if.rx_ack, byte_count);
    end
    for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
    send_frame(pl, 0);
    repeat (4) @(negedge clk);
    total++;
    if (cipher_out !== m_cipher || loaded !== 1'b1) begin
      bad++; $display("FAIL collide_frame: got %h ld=%b expected %h ld=1", cipher_out, loaded, m_cipher);
    end
    do_clear();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl [N];
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), int'($urandom_range(3, 1)));
    @(negedge clk);
    total++;
    if (byte_count !== 5'd7 || cipher_out !== m_cipher) begin
      bad++; $display("FAIL mid_partial: got cnt=%0d %h expected 7 %h", byte_count, cipher_out, m_cipher);
    end
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    total++;
    if (byte_count !== 5'd0 || cipher_out !== RV || loaded !== 1'b0 || rx_if.rx_ack !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got cnt=%0d %h ld=%b ack=%b expected 0 %h 0 0",
                      byte_count, cipher_out, loaded, rx_if.rx_ack, RV);
    end
    rst = 1'b1;
    for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
    send_frame(pl, 0);
    repeat (4) @(negedge clk);
    total++;
    if (cipher_out !== m_cipher || loaded !== 1'b1 || byte_count !== 5'(FRAME)) begin
      bad++; $display("FAIL mid_newframe: got %h ld=%b cnt=%0d expected %h ld=1 cnt=%0d",
                      cipher_out, loaded, byte_count, m_cipher, FRAME);
    end
    do_clear();
  endtask

`ifdef CIPHER_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] x;
    int s0;
    for (int pass = 0; pass < 2; pass++) begin
      x  = 8'h00;
      s0 = start_pulses;
      for (int i = 1; i <= N; i++) begin
        send_byte(8'(i), 2);
        x = x ^ 8'(i);
      end
      send_byte((pass == 0) ? x : 8'h00, 2);
      repeat (4) @(negedge clk);
      total++;
      if (cipher_out !== 128'h0102030405060708090A0B0C0D0E0F10) begin
        bad++; $display("FAIL chk_payload%0d: got %h expected 0102030405060708090a0b0c0d0e0f10", pass, cipher_out);
      end
      total++;
      if (loaded !== m_loaded || chk_err !== m_chk || byte_count !== 5'(m_count) || start_pulses - s0 !== (pass == 0 ? 1 : 0)) begin
        bad++; $display("FAIL chk_result%0d: got ld=%b ck=%b cnt=%0d starts=%0d expected ld=%b ck=%b cnt=%0d",
                        pass, loaded, chk_err, byte_count, start_pulses - s0, m_loaded, m_chk, m_count);
      end
      do_clear();
    end
  endtask
`endif

  initial begin
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    test_reset();
    test_frame();
    test_overrun_clear();
    test_busy();
    test_random_frames();
    test_timeout();
    test_clear_collision();
    test_reset_mid();
`ifdef CIPHER_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    total++;
    if (start_pulses !== m_starts) begin
      bad++; $display("FAIL start_total: got %0d expected %0d", start_pulses, m_starts);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
